// File: rtl/avg_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | avg_pkg : shared sizing constants/helpers for stream_block_averager       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package avg_pkg;

    localparam int MAX_LOG2_N_DEF = 8;
    localparam int N_W            = $clog2(MAX_LOG2_N_DEF + 1);

    // Accumulator needs MAX_LOG2_N guard bits so a full block of extreme samples fits.
    function automatic int acc_w(input int data_w, input int max_log2_n);
        return data_w + max_log2_n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_out_hold.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | stream_out_hold : one-entry ready/valid holding register, drop on full    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module stream_out_hold #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         drop_o
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         w_accept;

    // Slot is free if empty or if its current content leaves this cycle.
    assign w_accept = !valid_q || ready_i;
    assign drop_o   = load_i && !w_accept;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i && w_accept) begin
            data_d  = load_data_i;
            valid_d = 1'b1;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/stream_block_averager.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | stream_block_averager : one floor-average per 2**n_log2 input samples     |
// | Optional macro AVG_DROP_COUNT_EN adds a saturating drop_count port.       |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module stream_block_averager
    import avg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MAX_LOG2_N = MAX_LOG2_N_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [$clog2(MAX_LOG2_N+1)-1:0]   n_log2,
    input  logic                              clear,
    input  logic [DATA_W-1:0]                 data_in,
    input  logic                              data_in_valid,
    output logic [DATA_W-1:0]                 data_out0,
    output logic                              data_out_valid0,
    input  logic                              data_ready0
`ifdef AVG_DROP_COUNT_EN
   ,output logic [15:0]                       drop_count
`endif
);

    localparam int ACC_W = acc_w(DATA_W, MAX_LOG2_N);
    localparam int NL_W  = $clog2(MAX_LOG2_N + 1);
    localparam int CNT_W = MAX_LOG2_N + 1;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NL_W-1:0]         n_lat_q, n_lat_d;

    logic [NL_W-1:0]         w_n_eff, w_n_cur;
    logic [CNT_W-1:0]        w_last_idx;
    logic signed [ACC_W-1:0] w_sext, w_sum, w_shifted;
    logic                    w_take, w_last, w_drop;

    assign w_n_eff    = (n_log2 > NL_W'(MAX_LOG2_N)) ? NL_W'(MAX_LOG2_N) : n_log2;
    // The first sample of a block already uses the freshly sampled exponent (N=1 case).
    assign w_n_cur    = (cnt_q == '0) ? w_n_eff : n_lat_q;
    assign w_last_idx = (CNT_W'(1) << w_n_cur) - CNT_W'(1);
    assign w_take     = data_in_valid && !clear;
    assign w_last     = w_take && (cnt_q == w_last_idx);
    assign w_sext     = {{(ACC_W-DATA_W){data_in[DATA_W-1]}}, data_in};
    assign w_sum      = acc_q + w_sext;
    assign w_shifted  = w_sum >>> w_n_cur;

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        n_lat_d = n_lat_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (data_in_valid) begin
            if (cnt_q == '0) begin
                n_lat_d = w_n_eff;
            end
            if (w_last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = w_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            n_lat_q <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            n_lat_q <= n_lat_d;
        end
    end

    stream_out_hold #(
        .W (DATA_W)
    ) u_hold (
        .clk         (clk),
        .reset       (reset),
        .load_i      (w_last),
        .load_data_i (w_shifted[DATA_W-1:0]),
        .ready_i     (data_ready0),
        .data_o      (data_out0),
        .valid_o     (data_out_valid0),
        .drop_o      (w_drop)
    );

`ifdef AVG_DROP_COUNT_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= '0;
        end else if (w_drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_block_averager.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_stream_block_averager : directed vectors for stream_block_averager     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_stream_block_averager;

    localparam int NW = 4;

    logic          clk;
    logic          reset;
    logic [NW-1:0] n_log2;
    logic          clear;
    logic [31:0]   data_in;
    logic          data_in_valid;
    logic [31:0]   data_out0;
    logic          data_out_valid0;
    logic          data_ready0;
`ifdef AVG_DROP_COUNT_EN
    logic [15:0]   drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    stream_block_averager dut (
        .clk             (clk),
        .reset           (reset),
        .n_log2          (n_log2),
        .clear           (clear),
        .data_in         (data_in),
        .data_in_valid   (data_in_valid),
        .data_out0       (data_out0),
        .data_out_valid0 (data_out_valid0),
        .data_ready0     (data_ready0)
`ifdef AVG_DROP_COUNT_EN
       ,.drop_count      (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] n;
        logic          clr;
        logic          vld;
        logic [31:0]   din;
        logic          rdy;
        logic          exp_ov;
        logic [31:0]   exp_do;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [NW-1:0] n, input logic clr, input logic vld,
                       input logic [31:0] din, input logic rdy,
                       input logic exp_ov, input logic [31:0] exp_do);
        vec_t v;
        v.n = n; v.clr = clr; v.vld = vld; v.din = din; v.rdy = rdy;
        v.exp_ov = exp_ov; v.exp_do = exp_do;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [NW-1:0] n, input logic clr, input logic vld,
                       input logic [31:0] din, input logic rdy);
        n_log2        = n;
        clear         = clr;
        data_in_valid = vld;
        data_in       = din;
        data_ready0   = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; n_log2 = '0; clear = 1'b0; data_in = '0;
        data_in_valid = 1'b0; data_ready0 = 1'b1;
        #1;
        chk("reset_valid", {31'd0, data_out_valid0}, 32'd0);
        chk("reset_data", data_out0, 32'd0);
`ifdef AVG_DROP_COUNT_EN
        chk("reset_drop", {16'd0, drop_count}, 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;

        // Block of 4 averaging to 10, valid one cycle after the 4th sample.
        add(2, 0, 1, 32'd4,  1, 0, 0);
        add(2, 0, 1, 32'd8,  1, 0, 0);
        add(2, 0, 1, 32'd12, 1, 0, 0);
        add(2, 0, 1, 32'd16, 1, 1, 32'd10);
        add(2, 0, 0, 32'd0,  1, 0, 0);
        // Negative floor: -7/4 -> -2.
        add(2, 0, 1, 32'hFFFFFFFF, 1, 0, 0);
        add(2, 0, 1, 32'hFFFFFFFE, 1, 0, 0);
        add(2, 0, 1, 32'hFFFFFFFE, 1, 0, 0);
        add(2, 0, 1, 32'hFFFFFFFE, 1, 1, 32'hFFFFFFFE);
        // Max positive samples must not overflow.
        add(2, 0, 1, 32'h7FFFFFFF, 1, 0, 0);
        add(2, 0, 1, 32'h7FFFFFFF, 1, 0, 0);
        add(2, 0, 1, 32'h7FFFFFFF, 1, 0, 0);
        add(2, 0, 1, 32'h7FFFFFFF, 1, 1, 32'h7FFFFFFF);
        // Exponent change mid-block takes effect only on the next block.
        add(2, 0, 1, 32'd1, 1, 0, 0);
        add(2, 0, 1, 32'd2, 1, 0, 0);
        add(3, 0, 1, 32'd3, 1, 0, 0);
        add(3, 0, 1, 32'd6, 1, 1, 32'd3);
        for (int k = 1; k <= 8; k++) begin
            add(3, 0, 1, 32'(k), 1, (k == 8), (k == 8) ? 32'd4 : 32'd0);
        end
        add(3, 0, 0, 32'd0, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].n, tbl[i].clr, tbl[i].vld, tbl[i].din, tbl[i].rdy);
            chk($sformatf("vec%0d_valid", i), {31'd0, data_out_valid0}, {31'd0, tbl[i].exp_ov});
            if (tbl[i].exp_ov)
                chk($sformatf("vec%0d_data", i), data_out0, tbl[i].exp_do);
        end

        // Backpressure with N=1: second result dropped, first held.
        cyc(0, 0, 1, 32'd5, 0);
        chk("bp_first_valid", {31'd0, data_out_valid0}, 32'd1);
        chk("bp_first_data", data_out0, 32'd5);
        cyc(0, 0, 1, 32'd9, 0);
        chk("bp_hold_valid", {31'd0, data_out_valid0}, 32'd1);
        chk("bp_hold_data", data_out0, 32'd5);
`ifdef AVG_DROP_COUNT_EN
        chk("bp_drop_count", {16'd0, drop_count}, 32'd1);
`endif
        cyc(0, 0, 0, 32'd0, 0);
        chk("bp_idle_data", data_out0, 32'd5);
        // Same-cycle transfer and load: no drop.
        cyc(0, 0, 1, 32'd13, 1);
        chk("xfer_valid", {31'd0, data_out_valid0}, 32'd1);
        chk("xfer_data", data_out0, 32'd13);
`ifdef AVG_DROP_COUNT_EN
        chk("xfer_drop_count", {16'd0, drop_count}, 32'd1);
`endif
        cyc(0, 0, 0, 32'd0, 1);
        chk("xfer_empty", {31'd0, data_out_valid0}, 32'd0);

        // Clear after 3 of 4 samples; sample in the clear cycle discarded.
        for (int k = 0; k < 3; k++) cyc(2, 0, 1, 32'd1, 1);
        cyc(2, 1, 1, 32'd100, 1);
        chk("clr_no_result", {31'd0, data_out_valid0}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(2, 0, 1, 32'd1, 1);
            chk($sformatf("clr_partial%0d", k), {31'd0, data_out_valid0}, 32'd0);
        end
        cyc(2, 0, 1, 32'd1, 1);
        chk("clr_valid", {31'd0, data_out_valid0}, 32'd1);
        chk("clr_data", data_out0, 32'd1);

        // Async reset mid-block with a pending result.
        cyc(0, 0, 1, 32'd5, 0);
        cyc(2, 0, 1, 32'd7, 0);
        cyc(2, 0, 1, 32'd7, 0);
        chk("pre_rst_valid", {31'd0, data_out_valid0}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_valid", {31'd0, data_out_valid0}, 32'd0);
        chk("rst_async_data", data_out0, 32'd0);
`ifdef AVG_DROP_COUNT_EN
        chk("rst_async_drop", {16'd0, drop_count}, 32'd0);
`endif
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(2, 0, 1, 32'd1, 1);
            chk($sformatf("rst_partial%0d", k), {31'd0, data_out_valid0}, 32'd0);
        end
        cyc(2, 0, 1, 32'd1, 1);
        chk("rst_valid", {31'd0, data_out_valid0}, 32'd1);
        chk("rst_data", data_out0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
